// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: conditions ps2_clk/ps2_data on the quartz clock, checks 11-bit
// frames (odd parity) and assembles 3-byte packets presented with a one-cycle tx strobe.
module ps2_mouse_packet_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       qzt_clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] status,
    output logic [7:0] deltaX,
    output logic [7:0] deltaY,
    output logic       tx,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ((^{data, par}) == 1'b1);
    endfunction

    logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
    logic          filt_clk_r;
    logic [FW-1:0] filt_cnt_r;
    logic [TW-1:0] to_cnt_r;
    state_t        state_r;
    logic [3:0]    bit_cnt_r;
    logic [1:0]    idx_r;
    logic [7:0]    shift_r, byte0_r, byte1_r;
    logic          par_r;
    logic          fall_s, to_hit_s, busy_s;

    // Two-flop synchronisers for both PS/2 lines; idle level is high.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clk;
            clk_sync_r  <= clk_meta_r;
            data_meta_r <= ps2_data;
            data_sync_r <= data_meta_r;
        end
    end

    // Glitch filter: the level flips only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk_r <= 1'b1;
            filt_cnt_r <= '0;
        end else if (clk_sync_r != filt_clk_r) begin
            if (filt_cnt_r == FILT_LAST) begin
                filt_clk_r <= clk_sync_r;
                filt_cnt_r <= '0;
            end else begin
                filt_cnt_r <= filt_cnt_r + 1'b1;
            end
        end else begin
            filt_cnt_r <= '0;
        end
    end

    // Falling-edge strobe, timeout hit (an edge in the same cycle wins) and busy flag.
    always_comb begin
        fall_s   = 1'b0;
        to_hit_s = 1'b0;
        busy_s   = (bit_cnt_r != 4'd0) || (idx_r != 2'd0);
        if (filt_clk_r && !clk_sync_r && (filt_cnt_r == FILT_LAST)) begin
            fall_s = 1'b1;
        end else begin
            to_hit_s = (to_cnt_r == TO_LAST);
        end
    end

    // Idle counter: cleared by every filtered falling edge, saturating at TIMEOUT_CYCLES.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= '0;
        end else if (fall_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_MAX) begin
            to_cnt_r <= to_cnt_r + 1'b1;
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Frame and packet FSM with registered outputs and strobes.
    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_START;
            bit_cnt_r <= 4'd0;
            idx_r     <= 2'd0;
            shift_r   <= 8'h00;
            byte0_r   <= 8'h00;
            byte1_r   <= 8'h00;
            par_r     <= 1'b0;
            status    <= 8'h00;
            deltaX    <= 8'h00;
            deltaY    <= 8'h00;
            tx        <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx        <= 1'b0;
            frame_err <= 1'b0;
            if (fall_s) begin
                case (state_r)
                    ST_START: begin
                        // A high start bit is treated as noise and silently ignored.
                        if (!data_sync_r) begin
                            bit_cnt_r <= 4'd1;
                            state_r   <= ST_DATA;
                        end else begin
                            bit_cnt_r <= 4'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {data_sync_r, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd8) begin
                            state_r <= ST_PARITY;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        par_r     <= data_sync_r;
                        bit_cnt_r <= 4'd10;
                        state_r   <= ST_STOP;
                    end
                    ST_STOP: begin
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_START;
                        if (!odd_parity_ok(shift_r, par_r) || !data_sync_r) begin
                            idx_r     <= 2'd0;
                            frame_err <= 1'b1;
                        end else begin
                            case (idx_r)
                                2'd0: begin
                                    if (shift_r[3]) begin
                                        byte0_r <= shift_r;
                                        idx_r   <= 2'd1;
                                    end else begin
                                        frame_err <= 1'b1;
                                    end
                                end
                                2'd1: begin
                                    byte1_r <= shift_r;
                                    idx_r   <= 2'd2;
                                end
                                2'd2: begin
                                    status <= byte0_r;
                                    deltaX <= byte1_r;
                                    deltaY <= shift_r;
                                    tx     <= 1'b1;
                                    idx_r  <= 2'd0;
                                end
                                default: begin
                                    idx_r     <= 2'd0;
                                    frame_err <= 1'b1;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state_r   <= ST_START;
                        bit_cnt_r <= 4'd0;
                    end
                endcase
            end else if (to_hit_s && busy_s) begin
                state_r   <= ST_START;
                bit_cnt_r <= 4'd0;
                idx_r     <= 2'd0;
                frame_err <= 1'b1;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Scoreboard bench for ps2_mouse_packet_rx: directed PS/2 frames, expected tx/frame_err
// events queued at stimulus time and checked by an independent monitor.
module tb_ps2_mouse_packet_rx;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 2000;

    typedef struct packed {
        logic       is_err;
        logic [7:0] st;
        logic [7:0] dx;
        logic [7:0] dy;
    } exp_t;

    logic       qzt_clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] status, deltaX, deltaY;
    logic       tx, frame_err;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    ps2_mouse_packet_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .qzt_clk  (qzt_clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .status   (status),
        .deltaX   (deltaX),
        .deltaY   (deltaY),
        .tx       (tx),
        .frame_err(frame_err)
    );

    initial begin
        qzt_clk = 1'b0;
        forever #10 qzt_clk = ~qzt_clk;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge qzt_clk);
        #2;
    endtask

    task automatic push_tx(input logic [7:0] s, input logic [7:0] x, input logic [7:0] y);
        exp_q.push_back({1'b0, s, x, y});
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, 8'h00, 8'h00, 8'h00});
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic good_par);
        logic [10:0] f;
        f = {1'b1, (good_par ? ~(^b) : (^b)), b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        wait_cycles(2 * HALF);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, req);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] s, input logic [7:0] x,
                              input logic [7:0] y);
        check({tag, "_status"}, status, s);
        check({tag, "_deltaX"}, deltaX, x);
        check({tag, "_deltaY"}, deltaY, y);
        check({tag, "_tx"}, {7'd0, tx}, 8'h00);
        check({tag, "_frame_err"}, {7'd0, frame_err}, 8'h00);
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge qzt_clk) begin
        if (rst_n && (tx || frame_err)) begin
            total++;
            if (tx && frame_err) begin
                bad++;
                $display("FAIL tx_err_overlap: tx=%0b frame_err=%0b expected not both", tx, frame_err);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: tx=%0b frame_err=%0b expected none", tx, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err !== frame_err) begin
                    bad++;
                    $display("FAIL event_kind: frame_err=%0b expected %0b", frame_err, mon_e.is_err);
                end else if (tx && ({status, deltaX, deltaY} !== {mon_e.st, mon_e.dx, mon_e.dy})) begin
                    bad++;
                    $display("FAIL packet: got %02h/%02h/%02h expected %02h/%02h/%02h",
                             status, deltaX, deltaY, mon_e.st, mon_e.dx, mon_e.dy);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cycles(5);
        check_outs("reset", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;
        wait_cycles(20);

        // Basic packet
        push_tx(8'h28, 8'h05, 8'hFB);
        send_byte(8'h28, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'hFB, 1'b1);
        check_outs("pkt1", 8'h28, 8'h05, 8'hFB);

        // Parity error drops the partial packet
        push_err();
        send_byte(8'h08, 1'b1);
        send_byte(8'h10, 1'b0);
        push_tx(8'h09, 8'h01, 8'h02);
        send_byte(8'h09, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);

        // Misaligned first byte
        push_err();
        send_byte(8'h05, 1'b1);
        push_tx(8'h08, 8'h10, 8'h20);
        send_byte(8'h08, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);

        // Timeout abandons a partial packet
        push_err();
        send_byte(8'h08, 1'b1);
        send_byte(8'h7F, 1'b1);
        wait_cycles(TIMEOUT + TIMEOUT / 2);
        push_tx(8'h18, 8'hFF, 8'h80);
        send_byte(8'h18, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h80, 1'b1);
        check_outs("pkt4", 8'h18, 8'hFF, 8'h80);

        // Short glitch on ps2_clk while idle must be filtered out
        ps2_clk = 1'b0;
        wait_cycles(4);
        ps2_clk = 1'b1;
        wait_cycles(40);
        check_outs("glitch", 8'h18, 8'hFF, 8'h80);
        push_tx(8'h08, 8'h00, 8'h00);
        send_byte(8'h08, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);

        // Asynchronous reset in the middle of bit 5 of the second byte
        send_byte(8'h08, 1'b1);
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        ps2_data = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b0;
        wait_cycles(5);
        #3 rst_n = 1'b0;
        #1 check_outs("async_rst", 8'h00, 8'h00, 8'h00);
        wait_cycles(3);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst_n    = 1'b1;
        wait_cycles(20);
        push_tx(8'h38, 8'h80, 8'h7F);
        send_byte(8'h38, 1'b1);
        send_byte(8'h80, 1'b1);
        send_byte(8'h7F, 1'b1);

        // Drain: every expected event must have been observed
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) wait_cycles(1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d events pending expected 0", exp_q.size());
        end
        check_outs("final", 8'h38, 8'h80, 8'h7F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
